mul_issue_queue: RTL and testbench
==================================

# mul_issue_queue

Reservation station feeding the multiply unit from the dispatch stage. Holds up to DEPTH dispatched MUL/MULH/MULHSU/MULHU instructions, captures missing source operands from the common data bus (CDB), and issues the oldest operand-complete entry to the multiply unit as a one-cycle request carrying inst, pc and both operand values. It is the initiator side of the multiply unit's request interface. The multiply unit accepts one request every cycle and is never back-pressured.

## Interface
- DEPTH, 4: queue entries (2..8)
- TAG_W, 5: ROB/physical tag width
- clk_i  in  1  clock, all state on rising edge
- reset_ni  in  1  asynchronous, active-low reset
- dispatch_valid_i  in  1  new multiply instruction offered
- dispatch_ready_o  out  1  queue can accept this cycle
- dispatch_inst_i  in  32  raw instruction word
- dispatch_pc_i  in  32  instruction PC
- dispatch_rob_tag_i  in  TAG_W  destination tag
- dispatch_rs1_rdy_i / dispatch_rs2_rdy_i  in  1  operand value already valid
- dispatch_rs1_tag_i / dispatch_rs2_tag_i  in  TAG_W  producer tag when not ready
- dispatch_rs1_value_i / dispatch_rs2_value_i  in  32  operand value when ready
- cdb_valid_i  in  1  result broadcast valid
- cdb_tag_i  in  TAG_W  broadcast producer tag
- cdb_value_i  in  32  broadcast value
- flush_i  in  1  synchronous pipeline flush
- mul_request_o  out  1  issue strobe to multiply unit
- inst_o, pc_o  out  32  issued instruction and PC
- rs1_value_o, rs2_value_o  out  32  issued operands
- issue_rob_tag_o  out  TAG_W  tag of issued instruction
- occupancy_o  out  $clog2(DEPTH+1)  valid entry count

## Operation
- Entry fields: valid, inst, pc, rob_tag, per operand {rdy, tag, value}. Entries are age-ordered and compacting: index 0 oldest, valid entries contiguous from 0.
- Dispatch: accepted at an edge when dispatch_valid_i && dispatch_ready_o. dispatch_ready_o = (count < DEPTH), from registered count only; same-cycle issue does not raise it.
- Dispatch write slot = count, or count-1 if an issue happens at the same edge.
- Wakeup: on cdb_valid_i, every valid entry operand with rdy=0 and tag==cdb_tag_i latches cdb_value_i and sets rdy. Dispatch bypass: an incoming operand with rdy=0 whose tag matches the same-cycle CDB is written as ready with cdb_value_i.
- Select: lowest index with valid && rs1.rdy && rs2.rdy, from registered state. Operands woken this edge are eligible next cycle.
- Issue at the edge: selected entry's fields go into the output registers, mul_request_o=1, the entry is removed, and younger entries shift down by one. CDB capture applies to the shifted copies at the same edge.
- No eligible entry: mul_request_o=0 and the data outputs hold their last values.
- flush_i: at the edge, all entries are cleared, count=0, and mul_request_o=0. Dispatch and CDB in that cycle are ignored. Flush wins over every simultaneous event.
- Reset (async, any time, including mid-issue): all entries invalid, count=0, mul_request_o=0, inst_o=pc_o=rs1_value_o=rs2_value_o=0, issue_rob_tag_o=0, dispatch_ready_o=1, occupancy_o=0.

## Timing
- Fully-ready dispatch accepted at edge E: it is issued at edge E+1, with mul_request_o high during cycle E+1..E+2.
- Operand woken by CDB at edge E: issue at edge E+1 at the earliest.
- Throughput: one issue per cycle. Back-to-back ready entries issue on consecutive cycles.
- Full (count==DEPTH) with simultaneous issue: dispatch is still refused that cycle and accepted the next.
- Empty queue with a simultaneous dispatch: no issue that cycle.

## Structure
- Shared package ooo_pkg gets mul_iq_entry_t (packed struct of the fields above), operand_t {rdy, tag, value}, and the TAG_W default constant. The multiply unit and other reservation stations reuse them.
- One sub-module, mul_iq_select: combinational oldest-ready priority picker, DEPTH ready bits in, onehot plus index plus any_valid out.

## Test plan
- Reset release, then dispatch inst 0x023100b3, pc 0x4, rs1=0x1, rs2=0xf0000001, both ready. Required: mul_request_o high one cycle after acceptance, with matching inst/pc/values; occupancy returns to 0.
- Dispatch 0x023110b3 with rs1 waiting on tag 3, then 0x023130b3 fully ready. Required: 0x023130b3 issues first; CDB tag 3 value 0x2 delivers, and 0x023110b3 issues the next cycle with rs1_value_o=0x2.
- Dispatch with rs2 tag 7 while the CDB broadcasts tag 7 value 0x4 in the same cycle. Required: issue at E+1 with rs2_value_o=0x4.
- Fill 4 non-ready entries. Required: dispatch_ready_o=0. Then wake entry 0 while dispatch is held: refused that cycle, accepted the next; age order preserved.
- Flush with 3 entries plus a simultaneous dispatch and CDB. Required: occupancy_o=0, no mul_request_o afterwards.
- Assert reset_ni mid-issue. Required: all outputs zero immediately; first dispatch after release behaves as in the first scenario.

Source files
------------

// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: operand and multiply reservation-station
// entry layouts, plus the default tag width used by the issue queues.
package ooo_pkg;

   localparam int TAG_W_DEFAULT = 5;

   typedef struct packed {
      logic                     rdy;
      logic [TAG_W_DEFAULT-1:0] tag;
      logic [31:0]              value;
   } operand_t;

   typedef struct packed {
      logic                     valid;
      logic [31:0]              inst;
      logic [31:0]              pc;
      logic [TAG_W_DEFAULT-1:0] rob_tag;
      operand_t                 rs1;
      operand_t                 rs2;
   } mul_iq_entry_t;

endpackage

// File: rtl/mul_iq_select.sv
// Oldest-ready picker: lowest set bit of the ready vector wins.
module mul_iq_select #(
   parameter int DEPTH = 4
) (
   input  logic [DEPTH-1:0]         ready,
   output logic [DEPTH-1:0]         onehot,
   output logic [$clog2(DEPTH)-1:0] index,
   output logic                     any_valid
);

   // Scan from youngest to oldest so the oldest ready entry is the last write.
   always_comb begin
      onehot    = '0;
      index     = '0;
      any_valid = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (ready[i]) begin
            onehot    = '0;
            onehot[i] = 1'b1;
            index     = ($clog2(DEPTH))'(i);
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mul_issue_queue.sv
// Multiply reservation station: age-ordered, compacting queue that captures
// CDB results and issues the oldest operand-complete entry every cycle.
module mul_issue_queue
   import ooo_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = TAG_W_DEFAULT
) (
   input  logic                       clk_i,
   input  logic                       reset_ni,
   input  logic                       dispatch_valid_i,
   output logic                       dispatch_ready_o,
   input  logic [31:0]                dispatch_inst_i,
   input  logic [31:0]                dispatch_pc_i,
   input  logic [TAG_W-1:0]           dispatch_rob_tag_i,
   input  logic                       dispatch_rs1_rdy_i,
   input  logic                       dispatch_rs2_rdy_i,
   input  logic [TAG_W-1:0]           dispatch_rs1_tag_i,
   input  logic [TAG_W-1:0]           dispatch_rs2_tag_i,
   input  logic [31:0]                dispatch_rs1_value_i,
   input  logic [31:0]                dispatch_rs2_value_i,
   input  logic                       cdb_valid_i,
   input  logic [TAG_W-1:0]           cdb_tag_i,
   input  logic [31:0]                cdb_value_i,
   input  logic                       flush_i,
   output logic                       mul_request_o,
   output logic [31:0]                inst_o,
   output logic [31:0]                pc_o,
   output logic [31:0]                rs1_value_o,
   output logic [31:0]                rs2_value_o,
   output logic [TAG_W-1:0]           issue_rob_tag_o,
   output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = $clog2(DEPTH);

   logic [CNT_W-1:0] count_q, count_d, wr_slot;
   logic [31:0]      inst_q [DEPTH];
   logic [31:0]      inst_d [DEPTH];
   logic [31:0]      pc_q   [DEPTH];
   logic [31:0]      pc_d   [DEPTH];
   logic [TAG_W-1:0] rob_q  [DEPTH];
   logic [TAG_W-1:0] rob_d  [DEPTH];
   logic             r1_rdy_q [DEPTH];
   logic             r1_rdy_d [DEPTH];
   logic [TAG_W-1:0] r1_tag_q [DEPTH];
   logic [TAG_W-1:0] r1_tag_d [DEPTH];
   logic [31:0]      r1_val_q [DEPTH];
   logic [31:0]      r1_val_d [DEPTH];
   logic             r2_rdy_q [DEPTH];
   logic             r2_rdy_d [DEPTH];
   logic [TAG_W-1:0] r2_tag_q [DEPTH];
   logic [TAG_W-1:0] r2_tag_d [DEPTH];
   logic [31:0]      r2_val_q [DEPTH];
   logic [31:0]      r2_val_d [DEPTH];

   logic [DEPTH-1:0] ready_vec, sel_onehot;
   logic [IDX_W-1:0] sel_idx;
   logic             issue, accept;
   logic [31:0]      sel_inst, sel_pc, sel_r1, sel_r2;
   logic [TAG_W-1:0] sel_rob;

   assign dispatch_ready_o = (count_q < CNT_W'(DEPTH));
   assign occupancy_o      = count_q;
   assign accept           = dispatch_valid_i && dispatch_ready_o;
   assign issue            = |ready_vec;
   assign wr_slot          = count_q - CNT_W'(issue);

   // Valid entries are contiguous from slot 0, so validity follows the count.
   always_comb begin
      ready_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ready_vec[i] = (i < int'(count_q)) && r1_rdy_q[i] && r2_rdy_q[i];
      end
   end

   mul_iq_select #(.DEPTH(DEPTH)) u_select (
      .ready     (ready_vec),
      .onehot    (sel_onehot),
      .index     (sel_idx),
      .any_valid ()
   );

   // AND-OR mux of the selected entry's fields toward the output registers.
   always_comb begin
      sel_inst = '0;
      sel_pc   = '0;
      sel_r1   = '0;
      sel_r2   = '0;
      sel_rob  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         sel_inst = sel_inst | ({32{sel_onehot[i]}} & inst_q[i]);
         sel_pc   = sel_pc   | ({32{sel_onehot[i]}} & pc_q[i]);
         sel_r1   = sel_r1   | ({32{sel_onehot[i]}} & r1_val_q[i]);
         sel_r2   = sel_r2   | ({32{sel_onehot[i]}} & r2_val_q[i]);
         sel_rob  = sel_rob  | ({TAG_W{sel_onehot[i]}} & rob_q[i]);
      end
   end

   // Next entry state: compact over the issued slot, apply CDB wakeup to the
   // shifted copies, then write the dispatched entry with same-cycle bypass.
   always_comb begin
      inst_d   = inst_q;
      pc_d     = pc_q;
      rob_d    = rob_q;
      r1_rdy_d = r1_rdy_q;
      r1_tag_d = r1_tag_q;
      r1_val_d = r1_val_q;
      r2_rdy_d = r2_rdy_q;
      r2_tag_d = r2_tag_q;
      r2_val_d = r2_val_q;
      count_d  = count_q - CNT_W'(issue) + CNT_W'(accept);

      // The last slot never receives a shifted entry; when issue shifts it,
      // the count decrement leaves it invalid anyway.
      for (int i = 0; i < DEPTH - 1; i++) begin
         if (issue && (i >= int'(sel_idx))) begin
            inst_d[i]   = inst_q[i+1];
            pc_d[i]     = pc_q[i+1];
            rob_d[i]    = rob_q[i+1];
            r1_rdy_d[i] = r1_rdy_q[i+1];
            r1_tag_d[i] = r1_tag_q[i+1];
            r1_val_d[i] = r1_val_q[i+1];
            r2_rdy_d[i] = r2_rdy_q[i+1];
            r2_tag_d[i] = r2_tag_q[i+1];
            r2_val_d[i] = r2_val_q[i+1];
         end
      end

      for (int i = 0; i < DEPTH; i++) begin
         if (cdb_valid_i && !r1_rdy_d[i] && (r1_tag_d[i] == cdb_tag_i)) begin
            r1_rdy_d[i] = 1'b1;
            r1_val_d[i] = cdb_value_i;
         end
         if (cdb_valid_i && !r2_rdy_d[i] && (r2_tag_d[i] == cdb_tag_i)) begin
            r2_rdy_d[i] = 1'b1;
            r2_val_d[i] = cdb_value_i;
         end
      end

      for (int i = 0; i < DEPTH; i++) begin
         if (accept && (i == int'(wr_slot))) begin
            inst_d[i]   = dispatch_inst_i;
            pc_d[i]     = dispatch_pc_i;
            rob_d[i]    = dispatch_rob_tag_i;
            r1_tag_d[i] = dispatch_rs1_tag_i;
            r2_tag_d[i] = dispatch_rs2_tag_i;
            if (!dispatch_rs1_rdy_i && cdb_valid_i && (dispatch_rs1_tag_i == cdb_tag_i)) begin
               r1_rdy_d[i] = 1'b1;
               r1_val_d[i] = cdb_value_i;
            end else begin
               r1_rdy_d[i] = dispatch_rs1_rdy_i;
               r1_val_d[i] = dispatch_rs1_value_i;
            end
            if (!dispatch_rs2_rdy_i && cdb_valid_i && (dispatch_rs2_tag_i == cdb_tag_i)) begin
               r2_rdy_d[i] = 1'b1;
               r2_val_d[i] = cdb_value_i;
            end else begin
               r2_rdy_d[i] = dispatch_rs2_rdy_i;
               r2_val_d[i] = dispatch_rs2_value_i;
            end
         end
      end
   end

   // Queue and issue registers; flush empties the queue but leaves the issue
   // data outputs holding their last values.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         count_q         <= '0;
         mul_request_o   <= 1'b0;
         inst_o          <= '0;
         pc_o            <= '0;
         rs1_value_o     <= '0;
         rs2_value_o     <= '0;
         issue_rob_tag_o <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            inst_q[i]   <= '0;
            pc_q[i]     <= '0;
            rob_q[i]    <= '0;
            r1_rdy_q[i] <= 1'b0;
            r1_tag_q[i] <= '0;
            r1_val_q[i] <= '0;
            r2_rdy_q[i] <= 1'b0;
            r2_tag_q[i] <= '0;
            r2_val_q[i] <= '0;
         end
      end else if (flush_i) begin
         count_q       <= '0;
         mul_request_o <= 1'b0;
      end else begin
         count_q       <= count_d;
         mul_request_o <= issue;
         inst_q        <= inst_d;
         pc_q          <= pc_d;
         rob_q         <= rob_d;
         r1_rdy_q      <= r1_rdy_d;
         r1_tag_q      <= r1_tag_d;
         r1_val_q      <= r1_val_d;
         r2_rdy_q      <= r2_rdy_d;
         r2_tag_q      <= r2_tag_d;
         r2_val_q      <= r2_val_d;
         if (issue) begin
            inst_o          <= sel_inst;
            pc_o            <= sel_pc;
            rs1_value_o     <= sel_r1;
            rs2_value_o     <= sel_r2;
            issue_rob_tag_o <= sel_rob;
         end
      end
   end

endmodule

// File: tb/tb_mul_issue_queue.sv
// Scoreboard bench for mul_issue_queue: a queue-based reference model steps on
// every clock edge, pushes expected issues, and a negedge monitor compares.
module tb_mul_issue_queue;

   localparam int DEPTH = 4;
   localparam int TAG_W = 5;

   logic              clk_i = 1'b0;
   logic              reset_ni = 1'b0;
   logic              dispatch_valid_i, dispatch_ready_o;
   logic [31:0]       dispatch_inst_i, dispatch_pc_i;
   logic [TAG_W-1:0]  dispatch_rob_tag_i;
   logic              dispatch_rs1_rdy_i, dispatch_rs2_rdy_i;
   logic [TAG_W-1:0]  dispatch_rs1_tag_i, dispatch_rs2_tag_i;
   logic [31:0]       dispatch_rs1_value_i, dispatch_rs2_value_i;
   logic              cdb_valid_i;
   logic [TAG_W-1:0]  cdb_tag_i;
   logic [31:0]       cdb_value_i;
   logic              flush_i;
   logic              mul_request_o;
   logic [31:0]       inst_o, pc_o, rs1_value_o, rs2_value_o;
   logic [TAG_W-1:0]  issue_rob_tag_o;
   logic [2:0]        occupancy_o;

   mul_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk_i(clk_i), .reset_ni(reset_ni),
      .dispatch_valid_i(dispatch_valid_i), .dispatch_ready_o(dispatch_ready_o),
      .dispatch_inst_i(dispatch_inst_i), .dispatch_pc_i(dispatch_pc_i),
      .dispatch_rob_tag_i(dispatch_rob_tag_i),
      .dispatch_rs1_rdy_i(dispatch_rs1_rdy_i), .dispatch_rs2_rdy_i(dispatch_rs2_rdy_i),
      .dispatch_rs1_tag_i(dispatch_rs1_tag_i), .dispatch_rs2_tag_i(dispatch_rs2_tag_i),
      .dispatch_rs1_value_i(dispatch_rs1_value_i), .dispatch_rs2_value_i(dispatch_rs2_value_i),
      .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_value_i(cdb_value_i),
      .flush_i(flush_i), .mul_request_o(mul_request_o),
      .inst_o(inst_o), .pc_o(pc_o), .rs1_value_o(rs1_value_o), .rs2_value_o(rs2_value_o),
      .issue_rob_tag_o(issue_rob_tag_o), .occupancy_o(occupancy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [31:0]      inst;
      logic [31:0]      pc;
      logic [TAG_W-1:0] rob;
      logic             a_rdy;
      logic [TAG_W-1:0] a_tag;
      logic [31:0]      a_val;
      logic             b_rdy;
      logic [TAG_W-1:0] b_tag;
      logic [31:0]      b_val;
   } ent_t;

   ent_t mq[$];
   ent_t sb[$];
   logic model_req = 1'b0;
   logic model_accept = 1'b0;
   int   compared = 0;
   int   mismatched = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: oldest fully-ready entry leaves, CDB wakes the rest,
   // a dispatch is taken only if the queue was not full before the edge.
   always @(posedge clk_i or negedge reset_ni) begin
      int   pre;
      int   k;
      ent_t n;
      if (!reset_ni) begin
         mq.delete();
         model_req = 1'b0;
         model_accept = 1'b0;
      end else begin
         pre = mq.size();
         model_accept = 1'b0;
         if (flush_i) begin
            mq.delete();
            model_req = 1'b0;
         end else begin
            k = -1;
            foreach (mq[j]) if (k < 0 && mq[j].a_rdy && mq[j].b_rdy) k = j;
            model_req = (k >= 0);
            if (k >= 0) begin
               sb.push_back(mq[k]);
               mq.delete(k);
            end
            if (cdb_valid_i) begin
               foreach (mq[j]) begin
                  if (!mq[j].a_rdy && mq[j].a_tag == cdb_tag_i) begin
                     mq[j].a_rdy = 1'b1; mq[j].a_val = cdb_value_i;
                  end
                  if (!mq[j].b_rdy && mq[j].b_tag == cdb_tag_i) begin
                     mq[j].b_rdy = 1'b1; mq[j].b_val = cdb_value_i;
                  end
               end
            end
            if (dispatch_valid_i && pre < DEPTH) begin
               n = '{dispatch_inst_i, dispatch_pc_i, dispatch_rob_tag_i,
                     dispatch_rs1_rdy_i, dispatch_rs1_tag_i, dispatch_rs1_value_i,
                     dispatch_rs2_rdy_i, dispatch_rs2_tag_i, dispatch_rs2_value_i};
               if (!n.a_rdy && cdb_valid_i && n.a_tag == cdb_tag_i) begin
                  n.a_rdy = 1'b1; n.a_val = cdb_value_i;
               end
               if (!n.b_rdy && cdb_valid_i && n.b_tag == cdb_tag_i) begin
                  n.b_rdy = 1'b1; n.b_val = cdb_value_i;
               end
               mq.push_back(n);
               model_accept = 1'b1;
            end
         end
      end
   end

   // Monitor: compare handshake/occupancy every cycle, pop and compare issues.
   always @(negedge clk_i) begin
      ent_t e;
      if (!reset_ni) sb.delete();
      chk("mul_request", 32'(mul_request_o), 32'(model_req));
      chk("occupancy", 32'(occupancy_o), 32'(mq.size()));
      chk("dispatch_ready", 32'(dispatch_ready_o), 32'(mq.size() < DEPTH));
      if (reset_ni && model_req) begin
         if (sb.size() == 0) begin
            chk("scoreboard_underflow", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            if (mul_request_o) begin
               chk("inst", inst_o, e.inst);
               chk("pc", pc_o, e.pc);
               chk("rs1_value", rs1_value_o, e.a_val);
               chk("rs2_value", rs2_value_o, e.b_val);
               chk("rob_tag", 32'(issue_rob_tag_o), 32'(e.rob));
            end
         end
      end
   end

   task automatic idle();
      dispatch_valid_i = 0; dispatch_inst_i = '0; dispatch_pc_i = '0; dispatch_rob_tag_i = '0;
      dispatch_rs1_rdy_i = 0; dispatch_rs2_rdy_i = 0; dispatch_rs1_tag_i = '0;
      dispatch_rs2_tag_i = '0; dispatch_rs1_value_i = '0; dispatch_rs2_value_i = '0;
      cdb_valid_i = 0; cdb_tag_i = '0; cdb_value_i = '0; flush_i = 0;
   endtask

   task automatic disp(input logic [31:0] inst, input logic [31:0] pc, input logic [4:0] rt,
                       input logic a_rdy, input logic [4:0] a_tag, input logic [31:0] a_v,
                       input logic b_rdy, input logic [4:0] b_tag, input logic [31:0] b_v);
      dispatch_valid_i = 1; dispatch_inst_i = inst; dispatch_pc_i = pc; dispatch_rob_tag_i = rt;
      dispatch_rs1_rdy_i = a_rdy; dispatch_rs1_tag_i = a_tag; dispatch_rs1_value_i = a_v;
      dispatch_rs2_rdy_i = b_rdy; dispatch_rs2_tag_i = b_tag; dispatch_rs2_value_i = b_v;
   endtask

   task automatic cdb(input logic [4:0] t, input logic [31:0] v);
      cdb_valid_i = 1; cdb_tag_i = t; cdb_value_i = v;
   endtask

   task automatic tick();
      @(negedge clk_i);
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc;
      idle();
      repeat (3) @(negedge clk_i);
      chk("reset_inst", inst_o, 32'h0);
      reset_ni = 1;

      // single fully-ready instruction
      disp(32'h023100b3, 32'h4, 5'd1, 1, 5'd0, 32'h1, 1, 5'd0, 32'hf0000001);
      tick();
      repeat (3) tick();

      // waiting instruction overtaken by a younger ready one
      disp(32'h023110b3, 32'h8, 5'd2, 0, 5'd3, 32'h0, 1, 5'd0, 32'h5);
      tick();
      disp(32'h023130b3, 32'hc, 5'd4, 1, 5'd0, 32'h6, 1, 5'd0, 32'h7);
      tick();
      tick();
      cdb(5'd3, 32'h2);
      tick();
      repeat (3) tick();

      // dispatch bypass from same-cycle CDB
      disp(32'h02320133, 32'h10, 5'd5, 1, 5'd0, 32'h9, 0, 5'd7, 32'h0);
      cdb(5'd7, 32'h4);
      tick();
      repeat (3) tick();

      // fill, then wake entry 0 while a dispatch is held
      for (int i = 0; i < DEPTH; i++) begin
         disp(32'h100 + 32'(i), 32'h20 + 32'(4*i), 5'(8 + i), 0, 5'(10 + i), 32'h0, 1, 5'd0, 32'(i));
         tick();
      end
      chk("full_ready", 32'(dispatch_ready_o), 32'd0);
      acc = 1'b0;
      for (int t = 0; t < 10 && !acc; t++) begin
         disp(32'h200, 32'h40, 5'd20, 1, 5'd0, 32'haa, 1, 5'd0, 32'hbb);
         if (t == 0) cdb(5'd10, 32'h11);
         @(negedge clk_i);
         acc = model_accept;
         idle();
      end
      chk("held_dispatch_accepted", 32'(acc), 32'd1);
      for (int i = 1; i < DEPTH; i++) begin
         cdb(5'(10 + i), 32'h30 + 32'(i));
         tick();
      end
      repeat (4) tick();

      // flush with three entries plus simultaneous dispatch and CDB
      for (int i = 0; i < 3; i++) begin
         disp(32'h300 + 32'(i), 32'h50 + 32'(i), 5'(i), 0, 5'(20 + i), 32'h0, 1, 5'd0, 32'h1);
         tick();
      end
      flush_i = 1;
      disp(32'h400, 32'h60, 5'd9, 1, 5'd0, 32'h1, 1, 5'd0, 32'h2);
      cdb(5'd20, 32'h77);
      tick();
      chk("flush_occupancy", 32'(occupancy_o), 32'd0);
      repeat (3) tick();

      // asynchronous reset while a request is being presented
      disp(32'h023100b3, 32'h4, 5'd1, 1, 5'd0, 32'h1, 1, 5'd0, 32'hf0000001);
      tick();
      @(posedge clk_i);
      #2;
      chk("pre_reset_request", 32'(mul_request_o), 32'd1);
      reset_ni = 0;
      #1;
      chk("rst_req", 32'(mul_request_o), 32'd0);
      chk("rst_inst", inst_o, 32'd0);
      chk("rst_pc", pc_o, 32'd0);
      chk("rst_rs1", rs1_value_o, 32'd0);
      chk("rst_rs2", rs2_value_o, 32'd0);
      chk("rst_tag", 32'(issue_rob_tag_o), 32'd0);
      chk("rst_occ", 32'(occupancy_o), 32'd0);
      chk("rst_ready", 32'(dispatch_ready_o), 32'd1);
      repeat (2) @(negedge clk_i);
      reset_ni = 1;
      disp(32'h023100b3, 32'h4, 5'd1, 1, 5'd0, 32'h1, 1, 5'd0, 32'hf0000001);
      tick();
      repeat (3) tick();

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(99) < 60)
            disp($urandom, $urandom, 5'($urandom_range(31)),
                 1'($urandom_range(1)), 5'($urandom_range(7)), $urandom,
                 1'($urandom_range(1)), 5'($urandom_range(7)), $urandom);
         if ($urandom_range(99) < 50) cdb(5'($urandom_range(7)), $urandom);
         if ($urandom_range(99) < 2) flush_i = 1;
         tick();
      end

      // drain by broadcasting every tag
      for (int c = 0; c < 200 && mq.size() > 0; c++) begin
         cdb(5'(c % 8), $urandom);
         tick();
      end
      repeat (3) tick();
      chk("drain_occupancy", 32'(occupancy_o), 32'd0);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
